exec_writeback_unit: RTL and testbench

Execute/writeback stage directly downstream of the 8x8 register file.
- Accepts one decoded instruction at a time over a valid/ready handshake.
- Drives the register file read addresses (ra1/ra2) and consumes rd1/rd2.
- Computes an 8-bit result; ALU ops are single-cycle, MUL is an iterative 8-cycle shift-add.
- Writes the result back through wa3/wd3/we3 and keeps zero/carry flags.

---
 rtl/exec_writeback_unit_pkg.sv | 64 ++++++
 rtl/exec_writeback_unit_if.sv | 20 ++
 rtl/exec_writeback_unit_mul_iter.sv | 56 +++++
 rtl/exec_writeback_unit.sv | 162 ++++++++++++++++
 tb/tb_exec_writeback_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_writeback_unit_pkg.sv
// Shared definitions for the execute/writeback stage: widths, opcodes,
// FSM state encoding and the single-cycle ALU evaluation function.
package exec_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int MUL_ITER = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Returns {carry, result} for every op except MUL (MUL yields zeros here).
  function automatic logic [DATA_W:0] alu_eval(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_shl;
    logic [DATA_W-1:0]   w_res;
    logic                w_cy;
    w_sum = '0;
    w_shl = '0;
    w_res = '0;
    w_cy  = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[DATA_W-1:0];
        w_cy  = w_sum[DATA_W];
      end
      OP_SUB: begin
        // Bit DATA_W of the widened difference is the unsigned borrow.
        w_sum = {1'b0, a} - {1'b0, b};
        w_res = w_sum[DATA_W-1:0];
        w_cy  = w_sum[DATA_W];
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SLT: w_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL: begin
        // Widen first so the bits pushed out of the byte can be OR-reduced.
        w_shl = {{DATA_W{1'b0}}, a} << b[2:0];
        w_res = w_shl[DATA_W-1:0];
        w_cy  = |w_shl[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
    return {w_cy, w_res};
  endfunction

endpackage

// File: rtl/exec_writeback_unit_if.sv
// Instruction channel into the execute/writeback stage.
// Handshake: the producer holds in_valid and the instruction fields stable;
// a transfer happens on the rising edge where in_valid && in_ready are both 1.
interface exec_writeback_unit_if;
  import exec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] imm;
  logic              use_imm;

  modport master (output in_valid, op, rs1, rs2, rd, imm, use_imm,
                  input  in_ready);
  modport slave  (input  in_valid, op, rs1, rs2, rd, imm, use_imm,
                  output in_ready);
endinterface

// File: rtl/exec_writeback_unit_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, MUL_ITER cycles.
// o_done is high in the last iteration cycle and o_product is valid with it.
module mul_iter
  import exec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic                o_done,
  output logic [2*DATA_W-1:0] o_product
);

  localparam int               CNT_W   = $clog2(MUL_ITER);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MUL_ITER - 1);

  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic [2*DATA_W-1:0] w_acc_next;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  assign o_done    = r_busy && (r_cnt == LP_LAST);
  assign o_product = w_acc_next;

  // Load operands on start, then step one bit per cycle until the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{DATA_W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_writeback_unit.sv
// Execute/writeback stage behind the 8x8 register file.
// IDLE -> EXEC -> (MUL) -> WB -> IDLE; ALU ops write back two cycles after
// accept, MUL ten. Optional macro EXEC_MUL_EN adds the iterative multiplier;
// without it op 111 retires as a NOP (no write, flags untouched).
module exec_writeback_unit
  import exec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  exec_writeback_unit_if.slave  instr,
  output logic [ADDR_W-1:0]     ra1,
  output logic [ADDR_W-1:0]     ra2,
  input  logic [DATA_W-1:0]     rd1,
  input  logic [DATA_W-1:0]     rd2,
  output logic [ADDR_W-1:0]     wa3,
  output logic [DATA_W-1:0]     wd3,
  output logic                  we3,
  output logic                  busy,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output state_t                o_dbg_state
);

  state_t            r_state;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic [ADDR_W-1:0] r_ra1;
  logic [ADDR_W-1:0] r_ra2;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_we3;
  logic [ADDR_W-1:0] r_wa3;
  logic [DATA_W-1:0] r_wd3;
  logic              r_zero;
  logic              r_carry;

  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_alu;
  logic              w_is_mul;
  logic              w_fire;
  logic [DATA_W-1:0] w_res;
  logic              w_cy;

  assign w_b      = r_use_imm ? r_imm : rd2;
  assign w_alu    = alu_eval(r_op, rd1, w_b);
  assign w_is_mul = (r_op == OP_MUL);

`ifdef EXEC_MUL_EN
  logic                w_mul_start;
  logic                w_mul_done;
  logic [2*DATA_W-1:0] w_mul_product;

  assign w_mul_start = (r_state == ST_EXEC) && w_is_mul;

  mul_iter u_mul_iter (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (rd1),
    .i_b       (w_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );
`endif

  // Select what retires on this edge: the ALU result out of EXEC, or the
  // finished product out of MUL. A disabled MUL never fires (NOP).
  always_comb begin
    w_fire = 1'b0;
    w_res  = w_alu[DATA_W-1:0];
    w_cy   = w_alu[DATA_W];
    if ((r_state == ST_EXEC) && !w_is_mul) w_fire = 1'b1;
`ifdef EXEC_MUL_EN
    if ((r_state == ST_MUL) && w_mul_done) begin
      w_fire = 1'b1;
      w_res  = w_mul_product[DATA_W-1:0];
      w_cy   = |w_mul_product[2*DATA_W-1:DATA_W];
    end
`endif
  end

  // Main FSM with registered handshake, read-address and writeback outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_ADD;
      r_rd       <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
      r_ra1      <= '0;
      r_ra2      <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_we3      <= 1'b0;
      r_wa3      <= '0;
      r_wd3      <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (instr.in_valid && r_in_ready) begin
            r_op       <= instr.op;
            r_rd       <= instr.rd;
            r_imm      <= instr.imm;
            r_use_imm  <= instr.use_imm;
            r_ra1      <= instr.rs1;
            r_ra2      <= instr.rs2;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
`ifdef EXEC_MUL_EN
          r_state <= w_is_mul ? ST_MUL : ST_WB;
`else
          r_state <= ST_WB;
`endif
        end
`ifdef EXEC_MUL_EN
        ST_MUL: begin
          if (w_mul_done) r_state <= ST_WB;
        end
`endif
        ST_WB: begin
          r_we3      <= 1'b0;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
      // Writeback registers load on the edge entering WB; r0 is never written.
      if (w_fire) begin
        r_we3   <= (r_rd != '0);
        r_wa3   <= r_rd;
        r_wd3   <= w_res;
        r_zero  <= (w_res == '0);
        r_carry <= w_cy;
      end
    end
  end

  assign instr.in_ready = r_in_ready;
  assign busy           = r_busy;
  assign ra1            = r_ra1;
  assign ra2            = r_ra2;
  assign we3            = r_we3;
  assign wa3            = r_wa3;
  assign wd3            = r_wd3;
  assign flag_zero      = r_zero;
  assign flag_carry     = r_carry;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Bench for exec_writeback_unit: an environment register file, a reference
// model of the instruction set in plain integer arithmetic, and scenario tasks.
module tb_exec_writeback_unit;
  import exec_pkg::*;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [7:0] imm;
    logic       use_imm;
  } instr_t;

  localparam logic [7:0] RF_INIT [8] = '{8'h00, 8'h3c, 8'ha5, 8'h07,
                                         8'hf0, 8'h81, 8'h12, 8'hfe};

  localparam instr_t DIR_TBL [16] = '{
    '{OP_ADD, 3'd0, 3'd0, 3'd1, 8'h05, 1'b1},
    '{OP_ADD, 3'd0, 3'd0, 3'd1, 8'hff, 1'b1},
    '{OP_ADD, 3'd1, 3'd0, 3'd1, 8'hff, 1'b1},
    '{OP_SUB, 3'd1, 3'd1, 3'd2, 8'h00, 1'b0},
    '{OP_ADD, 3'd0, 3'd0, 3'd3, 8'h0f, 1'b1},
    '{OP_MUL, 3'd3, 3'd0, 3'd4, 8'h11, 1'b1},
    '{OP_ADD, 3'd0, 3'd0, 3'd5, 8'h20, 1'b1},
    '{OP_MUL, 3'd5, 3'd0, 3'd6, 8'h10, 1'b1},
    '{OP_ADD, 3'd0, 3'd0, 3'd7, 8'h80, 1'b1},
    '{OP_SLT, 3'd7, 3'd0, 3'd6, 8'h01, 1'b1},
    '{OP_ADD, 3'd0, 3'd0, 3'd7, 8'h81, 1'b1},
    '{OP_SHL, 3'd7, 3'd0, 3'd5, 8'h01, 1'b1},
    '{OP_ADD, 3'd1, 3'd0, 3'd0, 8'h01, 1'b1},
    '{OP_XOR, 3'd1, 3'd3, 3'd2, 8'h00, 1'b0},
    '{OP_OR,  3'd5, 3'd3, 3'd4, 8'h00, 1'b0},
    '{OP_AND, 3'd1, 3'd3, 3'd6, 8'h00, 1'b0}
  };

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ra1, ra2, wa3;
  logic [7:0] rd1, rd2, wd3;
  logic       we3, busy, flag_zero, flag_carry;
  state_t     dbg_state;

  always #5 clk = ~clk;

  exec_writeback_unit_if u_if ();

  exec_writeback_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (u_if),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .wa3         (wa3),
    .wd3         (wd3),
    .we3         (we3),
    .busy        (busy),
    .flag_zero   (flag_zero),
    .flag_carry  (flag_carry),
    .o_dbg_state (dbg_state)
  );

  // Environment register file: combinational read, write on rising edge.
  logic [7:0] rf [8] = RF_INIT;
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  always @(posedge clk) if (we3) rf[wa3] <= wd3;

  // ---------------- counters, model, scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_rf [8];
  logic [2:0] m_wa;
  logic [7:0] m_wd;
  logic       m_z, m_c;
  int         e_we_cnt, e_we_k, e_ready_k;
  logic [7:0] exp_q [$];
  int         o_we_cnt, o_we_k, o_ready_k;
  logic [2:0] ob_wa, ob_ra1, ob_ra2;
  logic [7:0] ob_wd;
  logic       ob_z, ob_c;

  // Architectural effect of one instruction, in plain integer arithmetic.
  task automatic model_step(input instr_t ins);
    int a, b, s, res, sa, sb;
    bit cy, wr;
    a = int'(m_rf[ins.rs1]);
    b = ins.use_imm ? int'(ins.imm) : int'(m_rf[ins.rs2]);
    wr = 1; cy = 0; res = 0;
    case (ins.op)
      3'd0: begin s = a + b; res = s % 256; cy = (s > 255); end
      3'd1: begin res = (a - b + 256) % 256; cy = (a < b); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: begin
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        res = (sa < sb) ? 1 : 0;
      end
      3'd6: begin s = a * (2 ** (b % 8)); res = s % 256; cy = (s / 256) != 0; end
      default: begin
`ifdef EXEC_MUL_EN
        s = a * b; res = s % 256; cy = (s >= 256);
`else
        wr = 0;
`endif
      end
    endcase
    e_ready_k = (wr && ins.op == 3'd7) ? 11 : 3;
    e_we_k    = (wr && ins.op == 3'd7) ? 10 : 2;
    e_we_cnt  = (wr && ins.rd != 3'd0) ? 1 : 0;
    if (e_we_cnt == 0) e_we_k = 0;
    if (wr) begin
      m_wa = ins.rd;
      m_wd = 8'(res);
      m_z  = (res == 0);
      m_c  = cy;
      if (ins.rd != 3'd0) m_rf[ins.rd] = 8'(res);
    end
    exp_q.push_back(m_wd);
  endtask

  // Driver: present one instruction, then watch until in_ready returns,
  // throwing random junk at the input while the unit is busy.
  task automatic run_instr(input instr_t ins);
    u_if.in_valid = 1'b1;
    u_if.op = ins.op; u_if.rs1 = ins.rs1; u_if.rs2 = ins.rs2;
    u_if.rd = ins.rd; u_if.imm = ins.imm; u_if.use_imm = ins.use_imm;
    @(posedge clk); #1;
    o_we_cnt = 0; o_we_k = 0; o_ready_k = 0;
    for (int k = 1; k <= 24; k++) begin
      u_if.in_valid = 1'($urandom_range(0, 1));
      u_if.op  = 3'($urandom_range(0, 7));
      u_if.rs1 = 3'($urandom_range(0, 7));
      u_if.rs2 = 3'($urandom_range(0, 7));
      u_if.rd  = 3'($urandom_range(0, 7));
      u_if.imm = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (we3 === 1'b1) begin
        o_we_cnt++;
        if (o_we_k == 0) o_we_k = k;
      end
      if (u_if.in_ready === 1'b1) begin
        o_ready_k = k;
        break;
      end
    end
    u_if.in_valid = 1'b0;
    ob_wa = wa3; ob_wd = wd3; ob_z = flag_zero; ob_c = flag_carry;
    ob_ra1 = ra1; ob_ra2 = ra2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    u_if.in_valid = 1'b0; u_if.op = 3'd0; u_if.rs1 = 3'd0; u_if.rs2 = 3'd0;
    u_if.rd = 3'd0; u_if.imm = 8'd0; u_if.use_imm = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = RF_INIT[i];
    m_wa = 3'd0; m_wd = 8'd0; m_z = 1'b0; m_c = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", u_if.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b expected 0", we3); end
    checks++; if ({wa3, wd3, ra1, ra2} !== 17'd0) begin errors++; $display("FAIL reset_regs: got wa3=%0h wd3=%0h ra1=%0h ra2=%0h expected all 0", wa3, wd3, ra1, ra2); end
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL reset_flags: got z=%b c=%b expected 0 0", flag_zero, flag_carry); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] exp_wd;
    for (int i = 0; i < 16; i++) begin
      model_step(DIR_TBL[i]);
      run_instr(DIR_TBL[i]);
      exp_wd = exp_q.pop_front();
      checks++; if (o_we_cnt != e_we_cnt) begin errors++; $display("FAIL dir_we3_count[%0d]: got %0d expected %0d", i, o_we_cnt, e_we_cnt); end
      checks++; if (o_we_k != e_we_k) begin errors++; $display("FAIL dir_we3_cycle[%0d]: got N+%0d expected N+%0d", i, o_we_k, e_we_k); end
      checks++; if (o_ready_k != e_ready_k) begin errors++; $display("FAIL dir_ready_cycle[%0d]: got N+%0d expected N+%0d", i, o_ready_k, e_ready_k); end
      checks++; if (ob_wa !== m_wa) begin errors++; $display("FAIL dir_wa3[%0d]: got %0h expected %0h", i, ob_wa, m_wa); end
      checks++; if (ob_wd !== exp_wd) begin errors++; $display("FAIL dir_wd3[%0d]: got %0h expected %0h", i, ob_wd, exp_wd); end
      checks++; if ({ob_z, ob_c} !== {m_z, m_c}) begin errors++; $display("FAIL dir_flags[%0d]: got z=%b c=%b expected z=%b c=%b", i, ob_z, ob_c, m_z, m_c); end
      checks++; if ({ob_ra1, ob_ra2} !== {DIR_TBL[i].rs1, DIR_TBL[i].rs2}) begin errors++; $display("FAIL dir_ra[%0d]: got %0d/%0d expected %0d/%0d", i, ob_ra1, ob_ra2, DIR_TBL[i].rs1, DIR_TBL[i].rs2); end
    end
  endtask

  task automatic test_random_back_to_back();
    instr_t     ins;
    logic [7:0] exp_wd;
    for (int i = 0; i < 60; i++) begin
      ins.op      = 3'($urandom_range(0, 7));
      ins.rs1     = 3'($urandom_range(0, 7));
      ins.rs2     = 3'($urandom_range(0, 7));
      ins.rd      = 3'($urandom_range(0, 7));
      ins.imm     = 8'($urandom_range(0, 255));
      ins.use_imm = 1'($urandom_range(0, 1));
      model_step(ins);
      run_instr(ins);
      exp_wd = exp_q.pop_front();
      checks++; if (o_we_cnt != e_we_cnt) begin errors++; $display("FAIL rnd_we3_count[%0d] op=%0d: got %0d expected %0d", i, ins.op, o_we_cnt, e_we_cnt); end
      checks++; if (o_we_k != e_we_k) begin errors++; $display("FAIL rnd_we3_cycle[%0d] op=%0d: got N+%0d expected N+%0d", i, ins.op, o_we_k, e_we_k); end
      checks++; if (o_ready_k != e_ready_k) begin errors++; $display("FAIL rnd_ready_cycle[%0d] op=%0d: got N+%0d expected N+%0d", i, ins.op, o_ready_k, e_ready_k); end
      checks++; if (ob_wa !== m_wa) begin errors++; $display("FAIL rnd_wa3[%0d]: got %0h expected %0h", i, ob_wa, m_wa); end
      checks++; if (ob_wd !== exp_wd) begin errors++; $display("FAIL rnd_wd3[%0d] op=%0d: got %0h expected %0h", i, ins.op, ob_wd, exp_wd); end
      checks++; if ({ob_z, ob_c} !== {m_z, m_c}) begin errors++; $display("FAIL rnd_flags[%0d] op=%0d: got z=%b c=%b expected z=%b c=%b", i, ins.op, ob_z, ob_c, m_z, m_c); end
      checks++; if ({ob_ra1, ob_ra2} !== {ins.rs1, ins.rs2}) begin errors++; $display("FAIL rnd_ra[%0d]: got %0d/%0d expected %0d/%0d", i, ob_ra1, ob_ra2, ins.rs1, ins.rs2); end
    end
  endtask

  task automatic test_reset_during_mul();
    instr_t     ins;
    int         we_seen;
    logic [7:0] exp_wd;
    // Leave carry set so the reset clearing it is visible.
    ins = '{OP_SUB, 3'd0, 3'd0, 3'd1, 8'h01, 1'b1};
    model_step(ins);
    run_instr(ins);
    exp_q.delete();
    u_if.in_valid = 1'b1; u_if.op = OP_MUL; u_if.rs1 = 3'd1; u_if.rs2 = 3'd0;
    u_if.rd = 3'd3; u_if.imm = 8'h03; u_if.use_imm = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    m_wa = 3'd0; m_wd = 8'd0; m_z = 1'b0; m_c = 1'b0;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midmul_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    checks++; if ({u_if.in_ready, busy} !== 2'b10) begin errors++; $display("FAIL midmul_ready_busy: got %b%b expected 10", u_if.in_ready, busy); end
    checks++; if ({we3, wa3, wd3} !== 12'd0) begin errors++; $display("FAIL midmul_wb: got we3=%b wa3=%0h wd3=%0h expected 0", we3, wa3, wd3); end
    checks++; if ({flag_zero, flag_carry} !== {m_z, m_c}) begin errors++; $display("FAIL midmul_flags: got z=%b c=%b expected 0 0", flag_zero, flag_carry); end
    @(negedge clk);
    rst = 1'b1;
    we_seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (we3 === 1'b1) we_seen++;
    end
    checks++; if (we_seen != 0) begin errors++; $display("FAIL midmul_no_write: got %0d pulses expected 0", we_seen); end
    ins = '{OP_ADD, 3'd1, 3'd0, 3'd2, 8'h01, 1'b1};
    model_step(ins);
    run_instr(ins);
    exp_wd = exp_q.pop_front();
    checks++; if ({o_we_cnt, o_we_k} != {e_we_cnt, e_we_k}) begin errors++; $display("FAIL post_reset_we3: got %0d@N+%0d expected %0d@N+%0d", o_we_cnt, o_we_k, e_we_cnt, e_we_k); end
    checks++; if (ob_wd !== exp_wd) begin errors++; $display("FAIL post_reset_wd3: got %0h expected %0h", ob_wd, exp_wd); end
    checks++; if ({ob_z, ob_c} !== {m_z, m_c}) begin errors++; $display("FAIL post_reset_flags: got z=%b c=%b expected z=%b c=%b", ob_z, ob_c, m_z, m_c); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random_back_to_back();
    test_reset_during_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
